// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request, ALU and response bundle for the shared-ALU arbiter
interface alu_share_arbiter_if #(
    parameter int W    = 4,
    parameter int OPW  = 2,
    parameter int CNTW = 8
);
    logic            req0_valid;
    logic            req0_ready;
    logic [W-1:0]    req0_a;
    logic [W-1:0]    req0_b;
    logic [OPW-1:0]  req0_op;
    logic            req1_valid;
    logic            req1_ready;
    logic [W-1:0]    req1_a;
    logic [W-1:0]    req1_b;
    logic [OPW-1:0]  req1_op;
    logic [W-1:0]    alu_inA;
    logic [W-1:0]    alu_inB;
    logic [OPW-1:0]  alu_op;
    logic [W-1:0]    alu_ans;
    logic            resp_valid;
    logic            resp_ready;
    logic [W-1:0]    resp_ans;
    logic            resp_id;
    logic            busy;
    logic [CNTW-1:0] op_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_ans, resp_ready,
        output req0_ready, req1_ready,
        output alu_inA, alu_inB, alu_op,
        output resp_valid, resp_ans, resp_id, busy, op_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_ans, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_inA, alu_inB, alu_op,
        input  resp_valid, resp_ans, resp_id, busy, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
    parameter int W    = 4,
    parameter int OPW  = 2,
    parameter int CNTW = 8
) (
    input logic                clk,
    input logic                rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q;
    logic            rr_q;
    logic            id_q;
    logic [W-1:0]    ina_q;
    logic [W-1:0]    inb_q;
    logic [OPW-1:0]  op_q;
    logic [W-1:0]    ans_q;
    logic [CNTW-1:0] cnt_q;
    logic            any_d;
    logic            grant_d;
    logic            accept_d;

    // Preferred requester wins when valid, otherwise the other one; ready is gated by reset
    always_comb begin
        any_d    = bus.req0_valid | bus.req1_valid;
        grant_d  = rr_q ? bus.req1_valid : ~bus.req0_valid;
        accept_d = rst_n & (state_q == IDLE) & any_d;
    end

    assign bus.req0_ready = accept_d & ~grant_d;
    assign bus.req1_ready = accept_d & grant_d;
    assign bus.alu_inA    = ina_q;
    assign bus.alu_inB    = inb_q;
    assign bus.alu_op     = op_q;
    assign bus.resp_ans   = ans_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_valid = state_q == RESP;
    assign bus.busy       = state_q != IDLE;
    assign bus.op_count   = cnt_q;

    // Accept -> one ALU cycle -> hold result until taken; pointer moves only on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            ina_q   <= '0;
            inb_q   <= '0;
            op_q    <= '0;
            ans_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (any_d) begin
                    ina_q   <= grant_d ? bus.req1_a : bus.req0_a;
                    inb_q   <= grant_d ? bus.req1_b : bus.req0_b;
                    op_q    <= grant_d ? bus.req1_op : bus.req0_op;
                    id_q    <= grant_d;
                    state_q <= EXEC;
                end
                EXEC: begin
                    ans_q   <= bus.alu_ans;
                    state_q <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    rr_q    <= ~id_q;
                    cnt_q   <= cnt_q + CNTW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed, table-driven and randomized checks of the shared-ALU arbiter
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu_share_arbiter_if bus ();

    alu_share_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b, logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign bus.alu_ans = alu_f(bus.alu_inA, bus.alu_inB, bus.alu_op);

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one op in flight, result due two cycles after accept
    bit         m_outst;
    int         m_age;
    bit         m_last = 1'b1;
    logic [7:0] m_cnt = '0;
    logic [3:0] m_ans;
    bit         m_id;
    bit         m_v0, m_v1, m_pref, m_g, m_r0, m_r1, m_rv;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_outst = 1'b0;
            m_age   = 0;
            m_last  = 1'b1;
            m_cnt   = '0;
        end else begin
            m_v0 = bus.req0_valid;
            m_v1 = bus.req1_valid;
            if (m_outst) m_age++;
            m_pref = ~m_last;
            m_g    = (m_pref ? m_v1 : m_v0) ? m_pref : ~m_pref;
            m_r0   = !m_outst && (m_v0 || m_v1) && !m_g;
            m_r1   = !m_outst && (m_v0 || m_v1) && m_g;
            m_rv   = m_outst && m_age >= 2;
            chk("mon_ready0", bus.req0_ready, m_r0);
            chk("mon_ready1", bus.req1_ready, m_r1);
            chk("mon_resp_valid", bus.resp_valid, m_rv);
            chk("mon_busy", bus.busy, m_outst);
            chk("mon_op_count", bus.op_count, m_cnt);
            if (m_rv) begin
                chk("mon_resp_ans", bus.resp_ans, m_ans);
                chk("mon_resp_id", bus.resp_id, m_id);
            end
            if (m_rv && bus.resp_ready) begin
                m_outst = 1'b0;
                m_last  = m_id;
                m_cnt++;
            end else if (m_r0 || m_r1) begin
                m_outst = 1'b1;
                m_age   = 0;
                m_id    = m_g;
                m_ans   = m_g ? alu_f(bus.req1_a, bus.req1_b, bus.req1_op)
                              : alu_f(bus.req0_a, bus.req0_b, bus.req0_op);
            end
        end
    end

    task automatic set_req(bit id, bit v, logic [3:0] a, logic [3:0] b, logic [1:0] op);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    task automatic run_op(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          output logic [3:0] ans, output bit rid, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        ans = 'x;
        rid = 1'b0;
        set_req(id, 1'b1, a, b, op);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = id ? bus.req1_ready : bus.req0_ready;
        end
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (!ok) begin
            chk("run_op_ready_timeout", 0, 1);
            return;
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            lat++;
            ok = bus.resp_valid;
        end
        if (!ok) chk("run_op_resp_timeout", 0, 1);
        ans = bus.resp_ans;
        rid = bus.resp_id;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl[8];
    logic [3:0] ans;
    bit         rid;
    int         lat;
    bit         ok;
    logic [7:0] c0;
    bit         hs0, hs1;
    int         nres;
    bit         ids[6];
    logic [3:0] anss[6];

    initial begin
        tbl[0] = '{1'b0, 4'h7, 4'h5, 2'd0, 4'hC};
        tbl[1] = '{1'b1, 4'hF, 4'h1, 2'd0, 4'h0};
        tbl[2] = '{1'b0, 4'h9, 4'h3, 2'd1, 4'h6};
        tbl[3] = '{1'b1, 4'h6, 4'h3, 2'd2, 4'h2};
        tbl[4] = '{1'b0, 4'h3, 4'h5, 2'd1, 4'hE};
        tbl[5] = '{1'b1, 4'hA, 4'h5, 2'd3, 4'hF};
        tbl[6] = '{1'b0, 4'hC, 4'hA, 2'd2, 4'h8};
        tbl[7] = '{1'b1, 4'h0, 4'h1, 2'd1, 4'hF};
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(0, 4'h7, 4'h5, 2'd0, ans, rid, lat);
        chk("single_ans", ans, 4'hC);
        chk("single_id", rid, 0);
        chk("single_latency", lat, 2);
        @(negedge clk);
        chk("single_op_count", bus.op_count, 1);
        @(posedge clk);
        #1;

        set_req(0, 1, 4'h3, 4'h2, 2'd0);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req0_ready;
        end
        chk("reset_pre_accept", ok, 1);
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_alu_inA", bus.alu_inA, 0);
        chk("rst_alu_inB", bus.alu_inB, 0);
        chk("rst_alu_op", bus.alu_op, 0);
        chk("rst_resp_ans", bus.resp_ans, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_op_count", bus.op_count, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_resp_valid", bus.resp_valid, 0);
        end
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            run_op(tbl[k].id, tbl[k].a, tbl[k].b, tbl[k].op, ans, rid, lat);
            chk($sformatf("tbl%0d_ans", k), ans, tbl[k].exp);
            chk($sformatf("tbl%0d_id", k), rid, tbl[k].id);
            chk($sformatf("tbl%0d_latency", k), lat, 2);
        end

        rst_n = 1'b0;
        set_req(0, 1, 4'h9, 4'h3, 2'd1);
        set_req(1, 1, 4'h6, 4'h3, 2'd2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        nres = 0;
        for (int i = 0; i < 60 && nres < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid && bus.resp_ready) begin
                ids[nres]  = bus.resp_id;
                anss[nres] = bus.resp_ans;
                nres++;
            end
        end
        chk("contention_count", nres, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("contention_id%0d", i), ids[i], i % 2);
            chk($sformatf("contention_ans%0d", i), anss[i], (i % 2) ? 4'h2 : 4'h6);
        end
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        bus.resp_ready = 1'b0;
        set_req(0, 1, 4'hA, 4'h3, 2'd3);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req0_ready;
        end
        chk("bp_accept", ok, 1);
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        set_req(1, 1, 4'h1, 4'h1, 2'd0);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = bus.resp_valid;
        end
        chk("bp_resp_valid", ok, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.resp_valid, 1);
            chk("bp_hold_ans", bus.resp_ans, 4'hB);
            chk("bp_hold_id", bus.resp_id, 0);
            chk("bp_busy", bus.busy, 1);
            chk("bp_no_ready1", bus.req1_ready, 0);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_ready1_after", bus.req1_ready, 1);
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = bus.resp_valid;
        end
        chk("bp_second_valid", ok, 1);
        chk("bp_second_ans", bus.resp_ans, 4'h2);
        chk("bp_second_id", bus.resp_id, 1);
        @(posedge clk);
        #1;

        @(negedge clk);
        c0 = bus.op_count;
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) begin
            run_op(i[0], 4'($urandom), 4'($urandom), 2'($urandom), ans, rid, lat);
            chk("wrap_id", rid, i[0]);
        end
        @(negedge clk);
        chk("wrap_op_count", bus.op_count, c0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            hs0 = bus.req0_valid && bus.req0_ready;
            hs1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk);
            #1;
            if (hs0 || !bus.req0_valid)
                set_req(0, $urandom_range(0, 2) != 0, 4'($urandom), 4'($urandom), 2'($urandom));
            else if ($urandom_range(0, 15) == 0)
                bus.req0_valid = 1'b0;
            if (hs1 || !bus.req1_valid)
                set_req(1, $urandom_range(0, 2) != 0, 4'($urandom), 4'($urandom), 2'($urandom));
            else if ($urandom_range(0, 15) == 0)
                bus.req1_valid = 1'b0;
            bus.resp_ready = $urandom_range(0, 3) != 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
